rop_dcr_bank: RTL and testbench

Device-configuration register bank for the ROP unit, generalised to `NUM_RT` render targets with shadow/active double buffering. The host writes ROP state through the DCR write bus into shadow registers. A COMMIT write copies the shadow set atomically into the active set once the ROP pipeline reports idle. The active set drives every ROP slice as one `rop_types::rop_dcrs_t` per render target: per-RT colour-buffer fields plus shared depth, stencil, blend and logic-op fields.

---
 rtl/rop_dcr_bank.sv | 189 ++++++++++++++++++
 tb/tb_rop_dcr_bank.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rop_dcr_bank.sv
// ROP device-configuration register bank: host writes land in a shadow set that a
// COMMIT copies atomically into the active set once the ROP pipeline is idle.

package rop_types;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] pitch;
    logic [31:0] mask;
  } rop_cbuf_t;

  typedef struct packed {
    logic [31:0] zbuf_addr;
    logic [31:0] zbuf_pitch;
    logic [2:0]  depth_func;
    logic        depth_writemask;
    logic [2:0]  stencil_front_func;
    logic [2:0]  stencil_back_func;
    logic [2:0]  stencil_front_zpass;
    logic [2:0]  stencil_back_zpass;
    logic [2:0]  stencil_front_zfail;
    logic [2:0]  stencil_back_zfail;
    logic [2:0]  stencil_front_fail;
    logic [2:0]  stencil_back_fail;
    logic [7:0]  stencil_front_ref;
    logic [7:0]  stencil_back_ref;
    logic [7:0]  stencil_front_mask;
    logic [7:0]  stencil_back_mask;
    logic [7:0]  stencil_writemask;
    logic [2:0]  blend_mode_rgb;
    logic [2:0]  blend_mode_a;
    logic [3:0]  blend_src_rgb;
    logic [3:0]  blend_src_a;
    logic [3:0]  blend_dst_rgb;
    logic [3:0]  blend_dst_a;
    logic [31:0] blend_const;  // {a, r, g, b}
    logic [3:0]  logic_op;
  } rop_common_t;

  typedef struct packed {
    rop_cbuf_t   cbuf;
    rop_common_t com;
  } rop_dcrs_t;

endpackage

module rop_dcr_bank
  import rop_types::*;
#(
  parameter int unsigned NUM_RT     = 4,
  parameter logic [11:0] DCR_BASE   = 12'h100,
  parameter int unsigned EPOCH_BITS = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 dcr_wr_valid,
  output logic                                 dcr_wr_ready,
  input  logic [11:0]                          dcr_wr_addr,
  input  logic [31:0]                          dcr_wr_data,
  input  logic                                 rop_busy,
  output logic [NUM_RT*$bits(rop_dcrs_t)-1:0]  dcrs,
  output logic                                 commit_done,
  output logic [EPOCH_BITS-1:0]                epoch
);

  localparam int unsigned W = $bits(rop_dcrs_t);

  typedef enum logic [0:0] {StIdle, StPending} state_e;

  state_e                r_state;
  logic                  r_ready;
  logic                  r_commit_done;
  logic [EPOCH_BITS-1:0] r_epoch;
  rop_common_t           r_com_shadow;
  rop_common_t           r_com_active;
  rop_cbuf_t             r_cb_shadow [NUM_RT];
  rop_cbuf_t             r_cb_active [NUM_RT];

  logic [11:0] w_offset;
  logic        w_in_range;
  logic        w_wr;
  logic        w_commit;

  assign w_offset   = dcr_wr_addr - DCR_BASE;
  assign w_in_range = (dcr_wr_addr >= DCR_BASE);
  assign w_wr       = dcr_wr_valid && r_ready && w_in_range;
  assign w_commit   = w_wr && (w_offset == 12'd14);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_com_shadow <= '0;
      for (int r = 0; r < NUM_RT; r++) r_cb_shadow[r] <= '0;
    end else if (w_wr) begin
      case (w_offset)
        12'd0:  r_com_shadow.zbuf_addr  <= dcr_wr_data;
        12'd1:  r_com_shadow.zbuf_pitch <= dcr_wr_data;
        12'd2: begin
          r_com_shadow.depth_func      <= dcr_wr_data[2:0];
          r_com_shadow.depth_writemask <= dcr_wr_data[3];
        end
        12'd3: begin
          r_com_shadow.stencil_front_func <= dcr_wr_data[2:0];
          r_com_shadow.stencil_back_func  <= dcr_wr_data[18:16];
        end
        12'd4: begin
          r_com_shadow.stencil_front_zpass <= dcr_wr_data[2:0];
          r_com_shadow.stencil_back_zpass  <= dcr_wr_data[18:16];
        end
        12'd5: begin
          r_com_shadow.stencil_front_zfail <= dcr_wr_data[2:0];
          r_com_shadow.stencil_back_zfail  <= dcr_wr_data[18:16];
        end
        12'd6: begin
          r_com_shadow.stencil_front_fail <= dcr_wr_data[2:0];
          r_com_shadow.stencil_back_fail  <= dcr_wr_data[18:16];
        end
        12'd7: begin
          r_com_shadow.stencil_front_ref <= dcr_wr_data[7:0];
          r_com_shadow.stencil_back_ref  <= dcr_wr_data[23:16];
        end
        12'd8: begin
          r_com_shadow.stencil_front_mask <= dcr_wr_data[7:0];
          r_com_shadow.stencil_back_mask  <= dcr_wr_data[23:16];
        end
        12'd9:  r_com_shadow.stencil_writemask <= dcr_wr_data[7:0];
        12'd10: begin
          r_com_shadow.blend_mode_rgb <= dcr_wr_data[2:0];
          r_com_shadow.blend_mode_a   <= dcr_wr_data[18:16];
        end
        12'd11: begin
          r_com_shadow.blend_src_rgb <= dcr_wr_data[3:0];
          r_com_shadow.blend_src_a   <= dcr_wr_data[11:8];
          r_com_shadow.blend_dst_rgb <= dcr_wr_data[19:16];
          r_com_shadow.blend_dst_a   <= dcr_wr_data[27:24];
        end
        12'd12: r_com_shadow.blend_const <= dcr_wr_data;
        12'd13: r_com_shadow.logic_op    <= dcr_wr_data[3:0];
        default: ;
      endcase
      // Per-RT triplets start at offset 16; RT indices past NUM_RT simply never match.
      for (int r = 0; r < NUM_RT; r++) begin
        if (w_offset == 12'(16 + 3 * r)) r_cb_shadow[r].addr  <= dcr_wr_data;
        if (w_offset == 12'(17 + 3 * r)) r_cb_shadow[r].pitch <= dcr_wr_data;
        if (w_offset == 12'(18 + 3 * r)) r_cb_shadow[r].mask  <= dcr_wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StIdle;
      r_ready       <= 1'b1;
      r_commit_done <= 1'b0;
      r_epoch       <= '0;
      r_com_active  <= '0;
      for (int r = 0; r < NUM_RT; r++) r_cb_active[r] <= '0;
    end else begin
      r_commit_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_commit) begin
            r_state <= StPending;
            r_ready <= 1'b0;
          end
        end
        StPending: begin
          if (!rop_busy) begin
            r_com_active <= r_com_shadow;
            for (int r = 0; r < NUM_RT; r++) r_cb_active[r] <= r_cb_shadow[r];
            r_epoch       <= r_epoch + 1'b1;
            r_commit_done <= 1'b1;
            r_ready       <= 1'b1;
            r_state       <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_RT; gi++) begin : g_slice
    assign dcrs[gi*W +: W] = {r_cb_active[gi], r_com_active};
  end

  assign dcr_wr_ready = r_ready;
  assign commit_done  = r_commit_done;
  assign epoch        = r_epoch;

endmodule

// File: tb/tb_rop_dcr_bank.sv
// Directed bench for rop_dcr_bank: shadow isolation, per-RT decode, busy stall,
// packed fields, epoch wrap and reset during a pending commit.

module tb_rop_dcr_bank;
  import rop_types::*;

  localparam int          NRT  = 4;
  localparam int          W    = $bits(rop_dcrs_t);
  localparam logic [11:0] BASE = 12'h100;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             dcr_wr_valid = 1'b0;
  logic             dcr_wr_ready;
  logic [11:0]      dcr_wr_addr = '0;
  logic [31:0]      dcr_wr_data = '0;
  logic             rop_busy = 1'b0;
  logic [NRT*W-1:0] dcrs;
  logic             commit_done;
  logic [1:0]       epoch;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;

  rop_dcr_bank #(
    .NUM_RT    (NRT),
    .DCR_BASE  (BASE),
    .EPOCH_BITS(2)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .dcr_wr_valid(dcr_wr_valid),
    .dcr_wr_ready(dcr_wr_ready),
    .dcr_wr_addr (dcr_wr_addr),
    .dcr_wr_data (dcr_wr_data),
    .rop_busy    (rop_busy),
    .dcrs        (dcrs),
    .commit_done (commit_done),
    .epoch       (epoch)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!reset && commit_done) n_pulses++;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rop_dcrs_t slice(input int i);
    return dcrs[i*W +: W];
  endfunction

  task automatic dcr_write(input logic [11:0] a, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    dcr_wr_valid = 1'b1;
    dcr_wr_addr  = a;
    dcr_wr_data  = d;
    while (!dcr_wr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!dcr_wr_ready) check_eq("wr_ready_timeout", dcr_wr_ready, 1);
    @(posedge clk);
    #1 dcr_wr_valid = 1'b0;
  endtask

  // Returns the number of negedges from COMMIT acceptance to seeing commit_done.
  task automatic wait_commit(output int lat);
    lat = 0;
    @(negedge clk);
    while (!commit_done && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check_eq("commit_done_seen", commit_done, 1);
  endtask

  task automatic do_commit(input string tag, input logic [1:0] exp_epoch);
    int lat;
    dcr_write(BASE + 12'd14, 32'h0);
    wait_commit(lat);
    check_eq({tag, "_lat"}, lat, 1);
    check_eq({tag, "_epoch"}, epoch, exp_epoch);
    check_eq({tag, "_ready"}, dcr_wr_ready, 1);
  endtask

  initial begin
    rop_dcrs_t   s;
    logic [31:0] v;
    int          bad;

    // Reset defaults
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    check_eq("rst_dcrs", |dcrs, 0);
    check_eq("rst_epoch", epoch, 0);
    check_eq("rst_ready", dcr_wr_ready, 1);
    check_eq("rst_commit_done", commit_done, 0);

    // Shadow isolation
    dcr_write(BASE + 12'd0, 32'h8000_0000);
    dcr_write(BASE + 12'd12, 32'hFF80_4020);
    @(negedge clk);
    check_eq("iso_no_commit", |dcrs, 0);
    do_commit("iso", 2'd1);
    for (int r = 0; r < NRT; r++) begin
      s = slice(r);
      check_eq($sformatf("iso_zbuf_rt%0d", r), s.com.zbuf_addr, 32'h8000_0000);
      check_eq($sformatf("iso_bc_a_rt%0d", r), s.com.blend_const[31:24], 8'hFF);
      check_eq($sformatf("iso_bc_r_rt%0d", r), s.com.blend_const[23:16], 8'h80);
      check_eq($sformatf("iso_bc_g_rt%0d", r), s.com.blend_const[15:8], 8'h40);
      check_eq($sformatf("iso_bc_b_rt%0d", r), s.com.blend_const[7:0], 8'h20);
    end
    @(negedge clk);
    check_eq("iso_pulse_one_cycle", commit_done, 0);

    // Per-RT decode plus ignored writes
    for (int r = 0; r < NRT; r++) begin
      v = 32'h1000 * (r + 1);
      dcr_write(BASE + 12'(16 + 3 * r), v);
    end
    dcr_write(BASE + 12'd28, 32'h0000_DEAD);
    dcr_write(12'h0FE, 32'hFFFF_FFFF);
    dcr_write(BASE + 12'd15, 32'hFFFF_FFFF);
    do_commit("rt", 2'd2);
    for (int r = 0; r < NRT; r++) begin
      s = slice(r);
      v = 32'h1000 * (r + 1);
      check_eq($sformatf("rt_cbuf_addr_rt%0d", r), s.cbuf.addr, v);
      check_eq($sformatf("rt_cbuf_pitch_rt%0d", r), s.cbuf.pitch, 0);
    end
    s = slice(0);
    check_eq("rt_zbuf_kept", s.com.zbuf_addr, 32'h8000_0000);
    check_eq("rt_zpitch_ign", s.com.zbuf_pitch, 0);
    check_eq("rt_logic_op_ign", s.com.logic_op, 0);

    // Busy stall with a write queued behind the commit
    rop_busy = 1'b1;
    dcr_write(BASE + 12'd14, 32'h0);
    @(negedge clk);
    dcr_wr_valid = 1'b1;
    dcr_wr_addr  = BASE + 12'd1;
    dcr_wr_data  = 32'h55;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (dcr_wr_ready || commit_done) bad++;
    end
    check_eq("stall_ready_low", bad, 0);
    check_eq("stall_epoch", epoch, 2);
    s = slice(0);
    check_eq("stall_active_kept", s.com.zbuf_pitch, 0);
    rop_busy = 1'b0;
    @(negedge clk);
    check_eq("stall_commit_done", commit_done, 1);
    check_eq("stall_ready_back", dcr_wr_ready, 1);
    check_eq("stall_epoch_inc", epoch, 3);
    s = slice(0);
    check_eq("stall_write_not_yet", s.com.zbuf_pitch, 0);
    @(posedge clk);
    #1 dcr_wr_valid = 1'b0;
    @(negedge clk);
    check_eq("stall_pulse_once", commit_done, 0);
    do_commit("wrap", 2'd0);
    s = slice(3);
    check_eq("stall_write_landed", s.com.zbuf_pitch, 32'h55);

    // Packed fields
    dcr_write(BASE + 12'd7, 32'h00AB_00CD);
    dcr_write(BASE + 12'd2, 32'h0000_000F);
    dcr_write(BASE + 12'd11, 32'h0F0E_0D0C);
    do_commit("pk", 2'd1);
    s = slice(2);
    check_eq("pk_st_front_ref", s.com.stencil_front_ref, 8'hCD);
    check_eq("pk_st_back_ref", s.com.stencil_back_ref, 8'hAB);
    check_eq("pk_depth_func", s.com.depth_func, 3'd7);
    check_eq("pk_depth_wmask", s.com.depth_writemask, 1);
    check_eq("pk_src_rgb", s.com.blend_src_rgb, 4'hC);
    check_eq("pk_src_a", s.com.blend_src_a, 4'hD);
    check_eq("pk_dst_rgb", s.com.blend_dst_rgb, 4'hE);
    check_eq("pk_dst_a", s.com.blend_dst_a, 4'hF);
    @(negedge clk);
    check_eq("pulse_count_5", n_pulses, 5);

    // Reset while a commit is pending
    rop_busy = 1'b1;
    dcr_write(BASE + 12'd0, 32'h0000_1234);
    dcr_write(BASE + 12'd14, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check_eq("prst_ready", dcr_wr_ready, 1);
    check_eq("prst_commit_done", commit_done, 0);
    check_eq("prst_dcrs", |dcrs, 0);
    check_eq("prst_epoch", epoch, 0);
    rop_busy = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("prst_no_pulse", n_pulses, 5);
    check_eq("prst_dcrs_still0", |dcrs, 0);
    do_commit("prst_recommit", 2'd1);
    check_eq("prst_shadow_cleared", |dcrs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
